// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch and data requesters.
// Data wins by default; a starvation counter forces a fetch grant after MAX_WAIT losses.
// Optional bus timeout: define ARB_TIMEOUT_EN.
// Ports:
//   clk, n_rst             clock, async active-low reset
//   if_req/if_addr         fetch request (level, held until if_ack)
//   if_ack/if_rdata        fetch done pulse and read data
//   d_req/d_we/d_addr/
//   d_wdata/d_be           data request (level, held until d_ack)
//   d_ack/d_rdata          data done pulse and load data
//   bus_err                pulses with the ack of an aborted access
//   mem_req/we/addr/
//   wdata/be               registered memory request, held until mem_ack
//   mem_ack/mem_rdata      memory completion and read data
module mem_port_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_ack,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_ack,
  output logic [DW-1:0]   d_rdata,
  output logic            bus_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WMAX = CW'(MAX_WAIT);

  if (MAX_WAIT < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("mem_port_arbiter: MAX_WAIT and TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   wait_cnt_q;
  logic            mem_req_q;
  logic            mem_we_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic [BW-1:0]   mem_be_q;
  logic            if_ack_q;
  logic            d_ack_q;
  logic [DW-1:0]   if_rdata_q;
  logic [DW-1:0]   d_rdata_q;

  logic gnt_i;
  logic gnt_d;

  // Fetch only wins a collision once it has lost MAX_WAIT times.
  always_comb begin
    gnt_i = if_req & (~d_req | (wait_cnt_q == WMAX));
    gnt_d = d_req & ~gnt_i;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] timer_q;
  logic          bus_err_q;
  logic          expire;

  // timer_q holds (BUSY cycle - 1); expiry is the TIMEOUT-th cycle.
  assign expire  = (timer_q == TLAST);
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      timer_q     <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      if_ack_q  <= 1'b0;
      d_ack_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      bus_err_q <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
`ifdef ARB_TIMEOUT_EN
          timer_q <= '0;
`endif
          if (gnt_i) begin
            state_q     <= BUSY_I;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
            mem_be_q    <= '1;
            wait_cnt_q  <= '0;
          end else if (gnt_d) begin
            state_q     <= BUSY_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            mem_be_q    <= d_be;
            if (if_req && wait_cnt_q != WMAX) begin
              wait_cnt_q <= wait_cnt_q + CW'(1);
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ack) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            if (state_q == BUSY_I) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= mem_rdata;
            end else begin
              d_ack_q <= 1'b1;
              if (!mem_we_q) begin
                d_rdata_q <= mem_rdata;
              end
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (expire) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            bus_err_q <= 1'b1;
            if (state_q == BUSY_I) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= '0;
            end else begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= '0;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
`endif
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus
// sequences for arbitration fairness, reset and timeout.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .bus_err   (bus_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  typedef struct {
    logic        ifr;
    logic [31:0] ifa;
    logic        dr;
    logic        dwe;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [3:0]  dbe;
    logic        mack;
    logic [31:0] mrd;
    logic        e_mreq;
    logic        e_mwe;
    logic [31:0] e_maddr;
    logic [31:0] e_mwd;
    logic [3:0]  e_mbe;
    logic        e_iack;
    logic [31:0] e_ird;
    logic        e_dack;
    logic [31:0] e_drd;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t row(
    input logic ifr, input logic [31:0] ifa,
    input logic dr, input logic dwe,
    input logic [31:0] da, input logic [31:0] dwd,
    input logic [3:0] dbe,
    input logic mack, input logic [31:0] mrd,
    input logic e_mreq, input logic e_mwe,
    input logic [31:0] e_maddr,
    input logic [31:0] e_mwd, input logic [3:0] e_mbe,
    input logic e_iack, input logic [31:0] e_ird,
    input logic e_dack, input logic [31:0] e_drd);
    vec_t v;
    v.ifr = ifr; v.ifa = ifa; v.dr = dr; v.dwe = dwe;
    v.da = da; v.dwd = dwd; v.dbe = dbe;
    v.mack = mack; v.mrd = mrd;
    v.e_mreq = e_mreq; v.e_mwe = e_mwe;
    v.e_maddr = e_maddr; v.e_mwd = e_mwd;
    v.e_mbe = e_mbe; v.e_iack = e_iack;
    v.e_ird = e_ird; v.e_dack = e_dack;
    v.e_drd = e_drd;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0;
    d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; d_be = '0;
    mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    if_req = v.ifr; if_addr = v.ifa;
    d_req = v.dr; d_we = v.dwe; d_addr = v.da;
    d_wdata = v.dwd; d_be = v.dbe;
    mem_ack = v.mack; mem_rdata = v.mrd;
    @(negedge clk);
    chk($sformatf("v%0d.mem_req", i), 32'(mem_req), 32'(v.e_mreq));
    if (v.e_mreq) begin
      chk($sformatf("v%0d.mem_we", i), 32'(mem_we), 32'(v.e_mwe));
      chk($sformatf("v%0d.mem_addr", i), mem_addr, v.e_maddr);
      chk($sformatf("v%0d.mem_wdata", i), mem_wdata, v.e_mwd);
      chk($sformatf("v%0d.mem_be", i), 32'(mem_be), 32'(v.e_mbe));
    end
    chk($sformatf("v%0d.if_ack", i), 32'(if_ack), 32'(v.e_iack));
    chk($sformatf("v%0d.if_rdata", i), if_rdata, v.e_ird);
    chk($sformatf("v%0d.d_ack", i), 32'(d_ack), 32'(v.e_dack));
    chk($sformatf("v%0d.d_rdata", i), d_rdata, v.e_drd);
    chk($sformatf("v%0d.bus_err", i), 32'(bus_err), 32'd0);
  endtask

  task automatic busy_hold(input bit late_ack,
                           input logic [31:0] rd);
    if_req = 1; if_addr = 32'h1000_0300;
    @(negedge clk);
    chk("to.grant", 32'(mem_req), 32'd1);
    repeat (14) @(negedge clk);
    chk("to.busy15", 32'(mem_req), 32'd1);
    if (late_ack) begin
      mem_ack = 1; mem_rdata = rd;
    end
    @(negedge clk);
    mem_ack = 0; if_req = 0;
`ifdef ARB_TIMEOUT_EN
    chk("to.if_ack", 32'(if_ack), 32'd1);
    chk("to.mem_req", 32'(mem_req), 32'd0);
    chk("to.bus_err", 32'(bus_err), late_ack ? 32'd0 : 32'd1);
    chk("to.if_rdata", if_rdata, late_ack ? rd : 32'd0);
`else
    chk("to.if_ack", 32'(if_ack), late_ack ? 32'd1 : 32'd0);
    chk("to.mem_req", 32'(mem_req), late_ack ? 32'd0 : 32'd1);
    chk("to.bus_err", 32'(bus_err), 32'd0);
    if (!late_ack) begin
      repeat (10) @(negedge clk);
      chk("to.still_busy", 32'(mem_req), 32'd1);
      mem_ack = 1; mem_rdata = rd;
      @(negedge clk);
      mem_ack = 0;
      chk("to.late_if_ack", 32'(if_ack), 32'd1);
      chk("to.late_rdata", if_rdata, rd);
    end
`endif
    @(negedge clk);
    chk("to.ack_clear", 32'(if_ack | bus_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    localparam logic [31:0] A = 32'h1000_0000;
    localparam logic [31:0] S = 32'h2000_0004;
    localparam logic [31:0] L = 32'h2000_0008;
    vecs[0]  = row(0,0, 0,0,0,0,0, 1,32'hFFFF_FFFF,
                   0,0,0,0,0, 0,0, 0,0);
    vecs[1]  = row(0,0, 0,0,0,0,0, 0,0,
                   0,0,0,0,0, 0,0, 0,0);
    vecs[2]  = row(1,A, 0,0,0,0,0, 0,0,
                   1,0,A,0,4'hF, 0,0, 0,0);
    vecs[3]  = row(1,A, 0,0,0,0,0, 1,32'h13,
                   0,0,0,0,0, 1,32'h13, 0,0);
    vecs[4]  = row(1,A, 0,0,0,0,0, 0,0,
                   0,0,0,0,0, 0,32'h13, 0,0);
    vecs[5]  = row(0,0, 0,0,0,0,0, 0,0,
                   0,0,0,0,0, 0,32'h13, 0,0);
    for (int i = 6; i < 10; i++)
      vecs[i] = row(0,0, 1,1,S,32'hDEAD_BEEF,4'b0011, 0,0,
                    1,1,S,32'hDEAD_BEEF,4'b0011, 0,32'h13, 0,0);
    vecs[10] = row(0,0, 1,1,S,32'hDEAD_BEEF,4'b0011,
                   1,32'h5555_5555,
                   0,0,0,0,0, 0,32'h13, 1,0);
    vecs[11] = row(0,0, 0,0,0,0,0, 0,0,
                   0,0,0,0,0, 0,32'h13, 0,0);
    vecs[12] = row(0,0, 1,0,L,0,4'hF, 0,0,
                   1,0,L,0,4'hF, 0,32'h13, 0,0);
    vecs[13] = row(0,0, 1,0,L,0,4'hF, 1,32'hCAFE_F00D,
                   0,0,0,0,0, 0,32'h13, 1,32'hCAFE_F00D);
    vecs[14] = row(0,0, 0,0,0,0,0, 1,32'h1234_5678,
                   0,0,0,0,0, 0,32'h13, 0,32'hCAFE_F00D);
    vecs[15] = row(0,0, 0,0,0,0,0, 1,32'h1234_5678,
                   0,0,0,0,0, 0,32'h13, 0,32'hCAFE_F00D);

    idle_inputs();
    n_rst = 0;
    repeat (2) @(negedge clk);
    chk("rst.mem_req", 32'(mem_req), 32'd0);
    chk("rst.acks", 32'({if_ack, d_ack, bus_err}), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.if_rdata", if_rdata, 32'd0);
    chk("rst.d_rdata", d_rdata, 32'd0);
    n_rst = 1;

    for (int i = 0; i < 16; i++) run_vec(i);

    // Both requesters held: data wins four times, then fetch.
    if_req = 1; if_addr = 32'h1000_0100;
    d_req = 1; d_we = 0; d_addr = 32'h2000_0100;
    d_wdata = '0; d_be = 4'hF;
    for (int k = 0; k < 6; k++) begin
      int n;
      bit exp_i;
      n = 0;
      @(negedge clk);
      while (!mem_req && n < 10) begin
        @(negedge clk);
        n++;
      end
      if (!mem_req) begin
        chk($sformatf("arb%0d.grant_timeout", k), 32'(mem_req), 32'd1);
        break;
      end
      exp_i = (k == 4);
      chk($sformatf("arb%0d.addr", k), mem_addr,
          exp_i ? 32'h1000_0100 : 32'h2000_0100);
      mem_ack = 1; mem_rdata = 32'h100 + 32'(k);
      @(negedge clk);
      mem_ack = 0;
      chk($sformatf("arb%0d.if_ack", k), 32'(if_ack), 32'(exp_i));
      chk($sformatf("arb%0d.d_ack", k), 32'(d_ack), 32'(!exp_i));
    end
    if_req = 0; d_req = 0;
    repeat (3) @(negedge clk);

    // Reset during a data transaction, then a fetch is served.
    d_req = 1; d_we = 1; d_addr = 32'h2000_0200;
    d_wdata = 32'h0BAD_F00D; d_be = 4'hF;
    @(negedge clk);
    chk("rst4.busy", 32'(mem_req), 32'd1);
    #2;
    n_rst = 0;
    if_req = 1; if_addr = 32'h1000_0200;
    #1;
    chk("rst4.mem_req_async", 32'(mem_req), 32'd0);
    chk("rst4.if_rdata", if_rdata, 32'd0);
    d_req = 0;
    @(negedge clk);
    chk("rst4.d_ack", 32'(d_ack), 32'd0);
    n_rst = 1;
    @(negedge clk);
    chk("rst4.fetch_req", 32'(mem_req), 32'd1);
    chk("rst4.fetch_addr", mem_addr, 32'h1000_0200);
    chk("rst4.fetch_we", 32'(mem_we), 32'd0);
    mem_ack = 1; mem_rdata = 32'h93;
    @(negedge clk);
    mem_ack = 0; if_req = 0;
    chk("rst4.if_ack", 32'(if_ack), 32'd1);
    chk("rst4.if_rdata_new", if_rdata, 32'h93);
    @(negedge clk);

    busy_hold(1'b0, 32'hA5A5_0001);
    busy_hold(1'b1, 32'hA5A5_0002);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
